// File: rtl/multiword_add_sequencer_pkg.sv
// multiword_add_sequencer_pkg: FSM state encoding and word-index width helper
// shared by the multiword add sequencer.
package multiword_add_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// ripple_carry_adder: NUMBITS-wide ripple carry adder slice used once per word
// by the multiword add sequencer.
module ripple_carry_adder #(
  parameter int NUMBITS = 16
) (
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
);
  logic [NUMBITS:0] w_c;
  assign w_c[0] = carryin;
  genvar i;
  for (i = 0; i < NUMBITS; i++) begin : g_fa
    assign result[i]  = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1]   = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end
  assign carryout = w_c[NUMBITS];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: NUMBITS*NUMWORDS-bit add, one word per cycle LSW first.
// Define SUBTRACT_EN to add the sub port (A-B via inverted B and forced carry-in).
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int NUMBITS  = 16,
  parameter int NUMWORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [NUMBITS*NUMWORDS-1:0] A,
  input  logic [NUMBITS*NUMWORDS-1:0] B,
  input  logic                        carryin,
`ifdef SUBTRACT_EN
  input  logic                        sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUMBITS*NUMWORDS-1:0] result,
  output logic                        carryout,
  output logic                        busy
);
  localparam int W  = NUMBITS * NUMWORDS;
  localparam int IW = idx_bits(NUMWORDS);

  state_t              r_state, w_next;
  logic [W-1:0]        r_a, r_b, r_result;
  logic [IW-1:0]       r_idx;
  logic                r_carry, r_carryout;
  logic [NUMBITS-1:0]  w_a, w_b, w_sum;
  logic                w_cout, w_last, w_accept;

  assign w_accept = start_valid && (r_state == IDLE);
  assign w_last   = r_idx == IW'(NUMWORDS - 1);
  assign w_a      = r_a[r_idx*NUMBITS +: NUMBITS];
`ifdef SUBTRACT_EN
  logic r_sub;
  assign w_b = r_b[r_idx*NUMBITS +: NUMBITS] ^ {NUMBITS{r_sub}};
`else
  assign w_b = r_b[r_idx*NUMBITS +: NUMBITS];
`endif

  ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
    .A       (w_a),
    .B       (w_b),
    .carryin (r_carry),
    .result  (w_sum),
    .carryout(w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_carryout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= A;
        r_b   <= B;
        r_idx <= '0;
`ifdef SUBTRACT_EN
        r_carry <= sub | carryin;
`else
        r_carry <= carryin;
`endif
      end
      if (r_state == RUN) begin
        r_result[r_idx*NUMBITS +: NUMBITS] <= w_sum;
        r_carry <= w_cout;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_carryout <= w_cout;
      end
    end
  end

`ifdef SUBTRACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sub <= 1'b0;
    else if (w_accept) r_sub <= sub;
  end
`endif

  assign start_ready = r_state == IDLE;
  assign out_valid   = r_state == DONE;
  assign busy        = r_state != IDLE;
  assign result      = r_result;
  assign carryout    = r_carryout;
endmodule
